// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin arbiter for valid/ready streams with a one-entry registered output stage.
// The rotating priority pointer advances past each granted requester so every active stream is served within N accepts.
module stream_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*DW-1:0]      in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [CW-1:0]        xfer_count
);

    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel;
    logic            has_sel;
    logic [DW-1:0]   sel_data;
    logic [2*N-1:0]  dbl;
    logic [SW-1:0]   sum;
    logic            load_en;
    logic            accept;
    logic            drain;

    assign load_en = !out_valid || out_ready;
    assign accept  = has_sel && load_en && !rst;
    assign drain   = out_valid && out_ready;

    // Rotate the request vector so bit 0 is the current highest-priority requester
    always_comb begin
        dbl     = {in_valid, in_valid} >> ptr;
        has_sel = 1'b0;
        sum     = '0;
        for (int k = 0; k < N; k++) begin
            if (!has_sel && dbl[k]) begin
                has_sel = 1'b1;
                sum     = {1'b0, ptr} + SW'(k);
            end
        end
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        sel = sum[IW-1:0];
    end

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sel_data    = in_data[i*DW +: DW];
                in_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            grant_idx  <= '0;
            xfer_count <= '0;
            ptr        <= '0;
        end else begin
            if (drain) begin
                xfer_count <= xfer_count + CW'(1);
            end
            if (accept) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
                grant_idx <= sel;
                ptr       <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios, a cycle-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [1:0]      grant_idx;
    logic [CW-1:0]   xfer_count;

    int total = 0;
    int bad = 0;
    bit checking = 0;

    // reference model state
    int          m_ptr = 0;
    bit          m_valid = 0;
    logic [31:0] m_data = '0;
    int          m_grant = 0;
    int          m_count = 0;

    stream_rr_arbiter #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .grant_idx(grant_idx), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // first valid requester in the order ptr, ptr+1, ..., wrapping; -1 if none
    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int s;
        s = rr_pick(m_ptr, in_valid);
        if (rst || s < 0 || (m_valid && !out_ready)) return '0;
        return N'(1) << s;
    endfunction

    always @(posedge clk) begin
        int s;
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_grant = 0; m_count = 0;
        end else begin
            s = rr_pick(m_ptr, in_valid);
            if (m_valid && out_ready) m_count = (m_count + 1) % (1 << CW);
            if (s >= 0 && (!m_valid || out_ready)) begin
                m_data  = in_data[s*DW +: DW];
                m_valid = 1;
                m_grant = s;
                m_ptr   = (s + 1) % N;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("model_in_ready", 32'(in_ready), 32'(model_ready()));
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_out_data", out_data, m_data);
            check("model_grant_idx", 32'(grant_idx), 32'(m_grant));
            check("model_xfer_count", 32'(xfer_count), 32'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = base + 32'(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        checking = 1;
        at_neg();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_xfer_count", 32'(xfer_count), 32'd0);
        check("reset_grant_idx", 32'(grant_idx), 32'd0);

        // single request from requester 2
        tick();
        in_data[2*DW +: DW] = 32'd42;
        in_valid = 4'b0100;
        out_ready = 1'b1;
        at_neg();
        check("single_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = '0;
        at_neg();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", out_data, 32'd42);
        check("single_grant", 32'(grant_idx), 32'd2);
        tick();
        at_neg();
        check("single_drained", 32'(out_valid), 32'd0);
        check("single_count", 32'(xfer_count), 32'd1);

        // all four requesters streaming at full rate
        do_reset();
        set_data(32'h100);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        at_neg();
        check("full_first_ready", 32'(in_ready), 32'b0001);
        for (int k = 1; k <= 8; k++) begin
            tick();
            at_neg();
            check("full_word", out_data, 32'h100 + 32'((k - 1) % 4));
        end
        tick();
        in_valid = '0;
        at_neg();
        check("full_count8", 32'(xfer_count), 32'd8);

        // back-pressure with a word from requester 1 held in the register
        do_reset();
        set_data(32'h200);
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check("stall_data", out_data, 32'h201);
            check("stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        at_neg();
        check("stall_release_ready", 32'(in_ready), 32'b1000);
        tick();
        at_neg();
        check("stall_next_grant", 32'(grant_idx), 32'd3);
        check("stall_next_data", out_data, 32'h203);
        tick();
        in_valid = '0;
        at_neg();
        check("stall_after_grant", 32'(grant_idx), 32'd0);

        // idle gap keeps the pointer at 1
        do_reset();
        set_data(32'h300);
        in_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        tick();
        at_neg();
        check("idle_drained", 32'(out_valid), 32'd0);
        tick();
        tick();
        in_valid = 4'b0011;
        at_neg();
        check("idle_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = '0;
        at_neg();
        check("idle_grant", 32'(grant_idx), 32'd1);

        // 17 handshakes wrap a 4-bit counter to 1
        do_reset();
        set_data(32'h400);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) tick();
        in_valid = '0;
        at_neg();
        check("wrap_count", 32'(xfer_count), 32'd1);

        // reset while a stalled word sits in the register
        do_reset();
        set_data(32'h500);
        in_valid = 4'b0100;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b0011;
        at_neg();
        check("midrst_loaded", 32'(out_valid), 32'd1);
        tick();
        rst = 1'b1;
        at_neg();
        check("midrst_ready", 32'(in_ready), 32'd0);
        tick();
        at_neg();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(xfer_count), 32'd0);
        check("midrst_grant", 32'(grant_idx), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        at_neg();
        check("midrst_after_ready", 32'(in_ready), 32'b0001);
        tick();
        in_valid = '0;
        at_neg();
        check("midrst_after_grant", 32'(grant_idx), 32'd0);
        check("midrst_after_data", out_data, 32'h500);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
